// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, request record and alucode encodings
// used by the shared-ALU arbiter and its ALU.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_CODE_W = 4;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_CODE_W-1:0] code;
    } alu_req_t;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SSL  = 4'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SSR  = 4'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd9;
    localparam logic [ALU_CODE_W-1:0] ALU_CPY  = 4'd10;

endpackage

// File: rtl/aluR32I.sv
// Combinational RV32I-style ALU. Shift amount is the low log2(DATA_W) bits of B;
// CPY passes operand A; undefined codes produce zero.
module aluR32I
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CODE_W = ALU_CODE_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] result
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;

    assign shamt = b[SHAMT_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        // NOTE: default assignment first so no code path can infer a latch.
        result = '0;
        case (code)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, lt_u};
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SSL:  result = a << shamt;
            ALU_SSR:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_CPY:  result = a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] && (!valid[1] || rr_last);
    assign grant[1] = valid[1] && (!valid[0] || !rr_last);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with
// round-robin arbitration and a single registered, id-tagged result stage.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CODE_W = ALU_CODE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CODE_W-1:0] req0_code,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CODE_W-1:0] req1_code,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result
);

    logic [1:0]        grant;
    logic              rr_last;
    logic              stage_free;
    logic              fire;
    logic              sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CODE_W-1:0] op_code;
    logic [DATA_W-1:0] alu_result;

    // The stage accepts a new op when empty or when its current result leaves this cycle.
    assign stage_free = !rsp_valid || rsp_ready;

    rr_arb2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .rr_last (rr_last),
        .grant   (grant)
    );

    assign req0_ready = stage_free && grant[0];
    assign req1_ready = stage_free && grant[1];
    assign fire       = req0_ready || req1_ready;
    assign sel        = grant[1];

    assign op_a    = sel ? req1_a    : req0_a;
    assign op_b    = sel ? req1_b    : req0_b;
    assign op_code = sel ? req1_code : req0_code;

    aluR32I #(
        .DATA_W (DATA_W),
        .CODE_W (CODE_W)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .code   (op_code),
        .result (alu_result)
    );

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rr_last    <= 1'b1;
        end else if (fire) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= sel;
            rsp_result <= alu_result;
            rr_last    <= sel;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, directed multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int W = ALU_DATA_W;
    localparam int C = ALU_CODE_W;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [C-1:0] req0_code, req1_code;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;

    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_code  (req0_code),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_code  (req1_code),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference ALU written from the instruction semantics.
    function automatic logic [W-1:0] ref_alu(input logic [C-1:0] code, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sa, sb, sh;
        longint unsigned ua, ub;
        sa = a; sb = b; ua = a; ub = b; sh = b % 32;
        case (code)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return (sa < sb) ? 1 : 0;
            ALU_SLTU: return (ua < ub) ? 1 : 0;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SSL:  return a << sh;
            ALU_SSR:  return a >> sh;
            ALU_SRA:  return sa >>> sh;
            ALU_CPY:  return a;
            default:  return '0;
        endcase
    endfunction

    task automatic drive(input int id, input logic v, input logic [C-1:0] code,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            req0_valid = v; req0_code = code; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_code = code; req1_a = a; req1_b = b;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1'b0, ALU_ADD, '0, '0);
        drive(1, 1'b0, ALU_ADD, '0, '0);
        rsp_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        string        name;
        int           id;
        logic [C-1:0] code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vt[12];

    // Random-phase model state.
    alu_req_t     pend [2];
    logic         pend_v [2];
    logic         m_valid;
    logic         m_id;
    logic [W-1:0] m_result;
    int           m_last;

    initial begin
        vt[0]  = '{"add",      0, ALU_ADD,  32'd9,          32'd4,          32'd13};
        vt[1]  = '{"sltu_neg", 0, ALU_SLTU, 32'hFFFF_FFFE,  32'd4,          32'd0};
        vt[2]  = '{"ssl",      0, ALU_SSL,  32'd9,          32'd1,          32'd18};
        vt[3]  = '{"cpy",      1, ALU_CPY,  32'hFFFF_FFF7,  32'h1234_5678,  32'hFFFF_FFF7};
        vt[4]  = '{"sra",      1, ALU_SRA,  32'hFFFF_FFF7,  32'd3,          32'hFFFF_FFFE};
        vt[5]  = '{"sub_neg",  0, ALU_SUB,  32'd9,          32'd10,         32'hFFFF_FFFF};
        vt[6]  = '{"slt",      1, ALU_SLT,  32'hFFFF_FFFF,  32'd0,          32'd1};
        vt[7]  = '{"add_wrap", 1, ALU_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000};
        vt[8]  = '{"ssr",      0, ALU_SSR,  32'h8000_0000,  32'd31,         32'd1};
        vt[9]  = '{"ssl_b5",   1, ALU_SSL,  32'd1,          32'd33,         32'd2};
        vt[10] = '{"xor",      0, ALU_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
        vt[11] = '{"and",      1, ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};

        do_reset();
        @(negedge clock);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset rsp_result", rsp_result, 0);
        step();

        // Single-requester vectors: ready same cycle, result one cycle later.
        rsp_ready = 1'b1;
        foreach (vt[i]) begin
            drive(vt[i].id, 1'b1, vt[i].code, vt[i].a, vt[i].b);
            @(negedge clock);
            check({vt[i].name, " ready"}, (vt[i].id == 0) ? req0_ready : req1_ready, 1);
            check({vt[i].name, " other_ready"}, (vt[i].id == 0) ? req1_ready : req0_ready, 0);
            step();
            drive(vt[i].id, 1'b0, ALU_ADD, '0, '0);
            @(negedge clock);
            check({vt[i].name, " rsp_valid"}, rsp_valid, 1);
            check({vt[i].name, " rsp_id"}, rsp_id, vt[i].id[0]);
            check({vt[i].name, " result"}, rsp_result, vt[i].exp);
            step();
        end

        // Tie right after reset goes to req0, then req1.
        do_reset();
        rsp_ready = 1'b1;
        drive(0, 1'b1, ALU_SUB, 32'd9, 32'd10);
        drive(1, 1'b1, ALU_SLT, 32'd2, 32'd4);
        @(negedge clock);
        check("tie req0_ready", req0_ready, 1);
        check("tie req1_ready", req1_ready, 0);
        step();
        drive(0, 1'b0, ALU_ADD, '0, '0);
        @(negedge clock);
        check("tie rsp0 id", rsp_id, 0);
        check("tie rsp0 result", rsp_result, 32'hFFFF_FFFF);
        check("tie req1_ready 2nd", req1_ready, 1);
        step();
        drive(1, 1'b0, ALU_ADD, '0, '0);
        @(negedge clock);
        check("tie rsp1 valid", rsp_valid, 1);
        check("tie rsp1 id", rsp_id, 1);
        check("tie rsp1 result", rsp_result, 32'd1);
        step();

        // Continuous contention alternates grants, one result per cycle.
        drive(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        drive(1, 1'b1, ALU_SUB, 32'd5, 32'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check($sformatf("alt grant0 c%0d", i), req0_ready, (i % 2) == 0);
            check($sformatf("alt grant1 c%0d", i), req1_ready, (i % 2) == 1);
            if (i > 0) begin
                check($sformatf("alt rsp_valid c%0d", i), rsp_valid, 1);
                check($sformatf("alt rsp_id c%0d", i), rsp_id, ((i - 1) % 2) == 1);
                check($sformatf("alt result c%0d", i), rsp_result, ((i - 1) % 2) == 1 ? 32'd2 : 32'd3);
            end
            step();
        end
        drive(0, 1'b0, ALU_ADD, '0, '0);
        drive(1, 1'b0, ALU_ADD, '0, '0);
        @(negedge clock);
        check("alt last id", rsp_id, 1);
        check("alt last result", rsp_result, 32'd2);
        step();

        // Backpressure holds the result and blocks both requesters; release pops and pushes together.
        do_reset();
        drive(1, 1'b1, ALU_SRA, 32'hFFFF_FFF7, 32'd3);
        @(negedge clock);
        check("bp req1_ready", req1_ready, 1);
        step();
        drive(1, 1'b0, ALU_ADD, '0, '0);
        drive(0, 1'b1, ALU_ADD, 32'd9, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("bp rsp_valid c%0d", i), rsp_valid, 1);
            check($sformatf("bp rsp_id c%0d", i), rsp_id, 1);
            check($sformatf("bp result c%0d", i), rsp_result, 32'hFFFF_FFFE);
            check($sformatf("bp req0_ready c%0d", i), req0_ready, 0);
            check($sformatf("bp req1_ready c%0d", i), req1_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        check("bp pop+push ready", req0_ready, 1);
        check("bp pop+push old result", rsp_result, 32'hFFFF_FFFE);
        step();
        drive(0, 1'b0, ALU_ADD, '0, '0);
        rsp_ready = 1'b0;
        @(negedge clock);
        check("bp new rsp_valid", rsp_valid, 1);
        check("bp new rsp_id", rsp_id, 0);
        check("bp new result", rsp_result, 32'd13);
        step();

        // Reset pulse drops a held result and restores req0 tie priority.
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("rst pulse rsp_valid", rsp_valid, 0);
        check("rst pulse rsp_id", rsp_id, 0);
        check("rst pulse result", rsp_result, 0);
        step();
        drive(0, 1'b1, ALU_OR, 32'h0F, 32'hF0);
        drive(1, 1'b1, ALU_OR, 32'h01, 32'h02);
        @(negedge clock);
        check("rst pulse tie req0", req0_ready, 1);
        check("rst pulse tie req1", req1_ready, 0);
        step();

        // Randomized traffic against the behavioural model.
        do_reset();
        m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_last = 1;
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic free;
            int   win;
            for (int r = 0; r < 2; r++) begin
                if (!pend_v[r] && $urandom_range(0, 9) < 6) begin
                    pend_v[r]    = 1'b1;
                    pend[r].a    = $urandom;
                    pend[r].b    = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 40)) : W'($urandom);
                    pend[r].code = C'($urandom_range(0, 11));
                end
                drive(r, pend_v[r], pend[r].code, pend[r].a, pend[r].b);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);

            free = !m_valid || rsp_ready;
            if (pend_v[0] && pend_v[1]) win = (m_last == 0) ? 1 : 0;
            else if (pend_v[0])         win = 0;
            else if (pend_v[1])         win = 1;
            else                        win = -1;

            @(negedge clock);
            check($sformatf("rnd req0_ready c%0d", cyc), req0_ready, free && win == 0);
            check($sformatf("rnd req1_ready c%0d", cyc), req1_ready, free && win == 1);
            check($sformatf("rnd rsp_valid c%0d", cyc), rsp_valid, m_valid);
            if (m_valid) begin
                check($sformatf("rnd rsp_id c%0d", cyc), rsp_id, m_id);
                check($sformatf("rnd result c%0d", cyc), rsp_result, m_result);
            end
            step();

            if (free && win >= 0) begin
                m_valid     = 1'b1;
                m_id        = (win == 1);
                m_result    = ref_alu(pend[win].code, pend[win].a, pend[win].b);
                m_last      = win;
                pend_v[win] = 1'b0;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
